// File: rtl/bram_vec_pkg.sv
// Shared types for the BRAM vector ALU: lane operation codes and the controller states.
// Latency: none, this file holds only types and constants.
// Backpressure: none, this file holds only types and constants.
package bram_vec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MAX = 2'd2,
    OP_MIN = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Deepest BRAM read latency that the read/valid pipe is built for.
  localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane ADD/SUB/MAX/MIN with optional clamping of ADD/SUB results.
// Latency: combinational; the caller registers the result.
// Backpressure: none (pure function of its inputs).
// Ports: a, b operands; op selects the operation; is_signed picks two's complement.
//        saturate clamps ADD/SUB; res is the lane result; sat flags a clamp.
module vec_lane_alu
  import bram_vec_pkg::*;
#(
  parameter int ELEM_W = 16
) (
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [1:0]        op,
  input  logic              is_signed,
  input  logic              saturate,
  output logic [ELEM_W-1:0] res,
  output logic              sat
);

  localparam logic [ELEM_W-1:0] S_MAX = {1'b0, {(ELEM_W-1){1'b1}}};
  localparam logic [ELEM_W-1:0] S_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

  logic [ELEM_W:0]   ext_a;
  logic [ELEM_W:0]   ext_b;
  logic [ELEM_W:0]   wide;
  logic              ovf;
  logic              a_gt_b;
  logic [ELEM_W-1:0] clamp;

  always_comb begin
    // One extra bit holds the full ADD/SUB result, so the range check is exact.
    ext_a = {is_signed & a[ELEM_W-1], a};
    ext_b = {is_signed & b[ELEM_W-1], b};
    wide  = (op == OP_SUB) ? (ext_a - ext_b) : (ext_a + ext_b);

    if (is_signed) begin
      // Signed overflow: the two top bits of the wide result disagree.
      ovf   = wide[ELEM_W] ^ wide[ELEM_W-1];
      clamp = wide[ELEM_W] ? S_MIN : S_MAX;
    end else begin
      // Unsigned: bit ELEM_W is the carry on ADD and the borrow on SUB.
      ovf   = wide[ELEM_W];
      clamp = (op == OP_SUB) ? '0 : '1;
    end

    a_gt_b = is_signed ? ($signed(a) > $signed(b)) : (a > b);

    res = wide[ELEM_W-1:0];
    sat = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        if (saturate && ovf) begin
          res = clamp;
          sat = 1'b1;
        end
      end
      OP_MAX:  res = a_gt_b ? a : b;
      default: res = a_gt_b ? b : a;
    endcase
  end

endmodule

// File: rtl/bram_vector_alu.sv
// Streams len lines from BRAM0/BRAM1, applies a lane-wise SIMD op, and writes the results to BRAM2.
// Latency: each write follows its read strobe by RD_LATENCY+1 cycles; start-to-done is len+RD_LATENCY+2.
// Backpressure: none, one read pair per cycle; i_abort squashes all in-flight work.
// Ports: i_clk/i_reset_n; i_start/i_abort control; i_len/i_op/i_signed/i_saturate config (start cycle only);
//        o_bram0/1_rd_* read ports with i_bram0/1_rd_data; o_bram2_wr_* write port;
//        o_busy (RUN/DRAIN), o_done (level in DONE), o_sat_seen (sticky clamp flag for this run).
module bram_vector_alu
  import bram_vec_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 256,
  parameter int ELEM_W     = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W:0]   i_len,
  input  logic [1:0]        i_op,
  input  logic              i_signed,
  input  logic              i_saturate,
  output logic              o_bram0_rd_en,
  output logic [ADDR_W-1:0] o_bram0_rd_addr,
  input  logic [DATA_W-1:0] i_bram0_rd_data,
  output logic              o_bram1_rd_en,
  output logic [ADDR_W-1:0] o_bram1_rd_addr,
  input  logic [DATA_W-1:0] i_bram1_rd_data,
  output logic              o_bram2_wr_en,
  output logic [ADDR_W-1:0] o_bram2_wr_addr,
  output logic [DATA_W-1:0] o_bram2_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sat_seen
);

  localparam int LANES = DATA_W / ELEM_W;

  state_e              state_q;
  state_e              state_d;
  op_e                 op_q;
  logic                signed_q;
  logic                saturate_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     rd_cnt_q;
  logic [RD_LATENCY-1:0] vld_pipe_q;
  logic [ADDR_W-1:0]   addr_pipe_q [RD_LATENCY];

  logic                idle_or_done;
  logic                active;
  logic                start_acc;
  logic                abort_acc;
  logic                last_rd;
  logic                pipe_empty;
  logic                rd_fire;
  logic                arrive;
  logic [DATA_W-1:0]   lane_res;
  logic [LANES-1:0]    lane_sat;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign active       = (state_q == RUN) || (state_q == DRAIN);
  assign abort_acc    = i_abort && active;
  // Abort takes priority over a start arriving in the same cycle.
  assign start_acc    = i_start && !i_abort && idle_or_done;
  assign last_rd      = (rd_cnt_q == len_q - 1'b1);
  assign pipe_empty   = (vld_pipe_q == '0);
  assign arrive       = vld_pipe_q[RD_LATENCY-1] && !abort_acc;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_acc) begin
          state_d = (i_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (last_rd) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // When the pipe is empty, the last line is in the output stage this cycle,
        // so it has retired by the time DONE becomes visible.
        if (i_abort) begin
          state_d = IDLE;
        end else if (pipe_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs. The abort term drops the read strobe in the abort cycle itself.
  always_comb begin
    rd_fire = (state_q == RUN) && !i_abort;
    o_busy  = active;
    o_done  = (state_q == DONE);
  end

  assign o_bram0_rd_en   = rd_fire;
  assign o_bram1_rd_en   = rd_fire;
  assign o_bram0_rd_addr = rd_cnt_q[ADDR_W-1:0];
  assign o_bram1_rd_addr = rd_cnt_q[ADDR_W-1:0];

  // Run configuration and read counter. The extra counter bit lets a full-BRAM run end cleanly.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_q       <= OP_ADD;
      signed_q   <= 1'b0;
      saturate_q <= 1'b0;
      len_q      <= '0;
      rd_cnt_q   <= '0;
    end else if (start_acc) begin
      op_q       <= op_e'(i_op);
      signed_q   <= i_signed;
      saturate_q <= i_saturate;
      len_q      <= i_len;
      rd_cnt_q   <= '0;
    end else if (rd_fire) begin
      rd_cnt_q   <= rd_cnt_q + 1'b1;
    end
  end

  // The valid/address pipe tracks each read until its data arrives. On arrival,
  // the lane results are registered straight into the BRAM2 write port.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_pipe_q      <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        addr_pipe_q[k] <= '0;
      end
      o_bram2_wr_en   <= 1'b0;
      o_bram2_wr_addr <= '0;
      o_bram2_wr_data <= '0;
      o_sat_seen      <= 1'b0;
    end else begin
      if (abort_acc) begin
        vld_pipe_q    <= '0;
        o_bram2_wr_en <= 1'b0;
      end else begin
        vld_pipe_q[0] <= rd_fire;
        for (int k = 1; k < RD_LATENCY; k++) begin
          vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
        o_bram2_wr_en <= vld_pipe_q[RD_LATENCY-1];
      end

      addr_pipe_q[0] <= rd_cnt_q[ADDR_W-1:0];
      for (int k = 1; k < RD_LATENCY; k++) begin
        addr_pipe_q[k] <= addr_pipe_q[k-1];
      end

      if (arrive) begin
        o_bram2_wr_addr <= addr_pipe_q[RD_LATENCY-1];
        o_bram2_wr_data <= lane_res;
      end

      if (start_acc) begin
        o_sat_seen <= 1'b0;
      end else if (arrive && (|lane_sat)) begin
        o_sat_seen <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    vec_lane_alu #(
      .ELEM_W(ELEM_W)
    ) u_lane (
      .a         (i_bram0_rd_data[j*ELEM_W +: ELEM_W]),
      .b         (i_bram1_rd_data[j*ELEM_W +: ELEM_W]),
      .op        (op_q),
      .is_signed (signed_q),
      .saturate  (saturate_q),
      .res       (lane_res[j*ELEM_W +: ELEM_W]),
      .sat       (lane_sat[j])
    );
  end

endmodule

// File: tb/tb_bram_vector_alu.sv
// Self-checking bench for bram_vector_alu: BRAM models plus an integer reference model of the lane rules.
// Latency: the bench checks write lag (RD_LATENCY+1) and start-to-done (len+RD_LATENCY+2, or 1 for len=0).
// Backpressure: not applicable; the bench checks abort squashing and ignored mid-run starts.
module tb_bram_vector_alu;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 256;
  localparam int ELEM_W = 16;
  localparam int RDL    = 2;
  localparam int LANES  = DATA_W / ELEM_W;
  localparam int MEM_N  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] MARKER = {(DATA_W/32){32'hDEADBEEF}};

  logic              i_clk;
  logic              i_reset_n;
  logic              i_start;
  logic              i_abort;
  logic [ADDR_W:0]   i_len;
  logic [1:0]        i_op;
  logic              i_signed;
  logic              i_saturate;
  logic              o_bram0_rd_en;
  logic [ADDR_W-1:0] o_bram0_rd_addr;
  logic [DATA_W-1:0] i_bram0_rd_data;
  logic              o_bram1_rd_en;
  logic [ADDR_W-1:0] o_bram1_rd_addr;
  logic [DATA_W-1:0] i_bram1_rd_data;
  logic              o_bram2_wr_en;
  logic [ADDR_W-1:0] o_bram2_wr_addr;
  logic [DATA_W-1:0] o_bram2_wr_data;
  logic              o_busy;
  logic              o_done;
  logic              o_sat_seen;

  bram_vector_alu #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ELEM_W(ELEM_W), .RD_LATENCY(RDL)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
    .i_len(i_len), .i_op(i_op), .i_signed(i_signed), .i_saturate(i_saturate),
    .o_bram0_rd_en(o_bram0_rd_en), .o_bram0_rd_addr(o_bram0_rd_addr), .i_bram0_rd_data(i_bram0_rd_data),
    .o_bram1_rd_en(o_bram1_rd_en), .o_bram1_rd_addr(o_bram1_rd_addr), .i_bram1_rd_data(i_bram1_rd_data),
    .o_bram2_wr_en(o_bram2_wr_en), .o_bram2_wr_addr(o_bram2_wr_addr), .o_bram2_wr_data(o_bram2_wr_data),
    .o_busy(o_busy), .o_done(o_done), .o_sat_seen(o_sat_seen)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [DATA_W-1:0] mem0 [MEM_N];
  logic [DATA_W-1:0] mem1 [MEM_N];
  logic [DATA_W-1:0] mem2 [MEM_N];
  logic [DATA_W-1:0] rd0_pipe [RDL];
  logic [DATA_W-1:0] rd1_pipe [RDL];

  // Read model: data for a strobe in cycle t is presented during cycle t+RDL.
  always @(posedge i_clk) begin
    rd0_pipe[0] <= o_bram0_rd_en ? mem0[o_bram0_rd_addr] : '0;
    rd1_pipe[0] <= o_bram1_rd_en ? mem1[o_bram1_rd_addr] : '0;
    for (int k = 1; k < RDL; k++) begin
      rd0_pipe[k] <= rd0_pipe[k-1];
      rd1_pipe[k] <= rd1_pipe[k-1];
    end
  end
  assign i_bram0_rd_data = rd0_pipe[RDL-1];
  assign i_bram1_rd_data = rd1_pipe[RDL-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt, wr_cnt, first_rd, first_wr, last_wr, addr_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_counts();
    rd_cnt = 0; wr_cnt = 0; first_rd = -1; first_wr = -1; last_wr = -1; addr_bad = 0;
  endtask

  // Advance to the next falling edge and record the strobes of the cycle just entered.
  task automatic step();
    @(negedge i_clk);
    cyc++;
    if (o_bram0_rd_en || o_bram1_rd_en) begin
      if (!(o_bram0_rd_en && o_bram1_rd_en) || o_bram0_rd_addr != o_bram1_rd_addr ||
          int'(o_bram0_rd_addr) != (rd_cnt % MEM_N)) addr_bad++;
      if (first_rd < 0) first_rd = cyc;
      rd_cnt++;
    end
    if (o_bram2_wr_en) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      mem2[o_bram2_wr_addr] = o_bram2_wr_data;
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] l;
    for (int k = 0; k < DATA_W/32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      mem0[i] = rand_line();
      mem1[i] = rand_line();
    end
  endtask

  // Reference: each lane is an integer in its numeric range, then clamped or wrapped.
  function automatic logic [DATA_W-1:0] ref_line(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input int op, input bit sgn, input bit sat, output bit any_sat);
    logic [DATA_W-1:0] r_line;
    logic [ELEM_W-1:0] ea, eb;
    int av, bv, r, lo, hi;
    any_sat = 1'b0;
    r_line  = '0;
    lo = sgn ? -(1 << (ELEM_W-1)) : 0;
    hi = sgn ? (1 << (ELEM_W-1)) - 1 : (1 << ELEM_W) - 1;
    for (int j = 0; j < LANES; j++) begin
      ea = a[j*ELEM_W +: ELEM_W];
      eb = b[j*ELEM_W +: ELEM_W];
      av = int'(ea);
      bv = int'(eb);
      if (sgn && ea[ELEM_W-1]) av = av - (1 << ELEM_W);
      if (sgn && eb[ELEM_W-1]) bv = bv - (1 << ELEM_W);
      case (op)
        0:       r = av + bv;
        1:       r = av - bv;
        2:       r = (av > bv) ? av : bv;
        default: r = (av < bv) ? av : bv;
      endcase
      if (op < 2 && sat && (r < lo || r > hi)) begin
        r = (r < lo) ? lo : hi;
        any_sat = 1'b1;
      end
      r_line[j*ELEM_W +: ELEM_W] = r[ELEM_W-1:0];
    end
    return r_line;
  endfunction

  task automatic run_job(input string tag, input int len, input int op, input bit sgn, input bit sat, input bit poke);
    logic [DATA_W-1:0] exp_line;
    bit s, exp_sat, got;
    int t0, lat, bad;
    for (int i = 0; i < MEM_N; i++) mem2[i] = MARKER;
    reset_counts();
    i_start = 1'b1; i_len = len[ADDR_W:0]; i_op = op[1:0]; i_signed = sgn; i_saturate = sat;
    t0 = cyc;
    step();
    // Configuration is don't-care after the start cycle.
    i_start = 1'b0; i_len = ADDR_W'($urandom); i_op = 2'($urandom);
    i_signed = 1'($urandom); i_saturate = 1'($urandom);
    got = 1'b0; lat = -1;
    for (int k = 0; k < len + RDL + 20; k++) begin
      if (o_done) begin
        got = 1'b1; lat = cyc - t0;
        break;
      end
      i_start = poke && (k == 5);
      step();
    end
    i_start = 1'b0;
    exp_sat = 1'b0; bad = 0;
    for (int i = 0; i < len; i++) begin
      exp_line = ref_line(mem0[i], mem1[i], op, sgn, sat, s);
      exp_sat |= s;
      if (mem2[i] !== exp_line) bad++;
    end
    if (len < MEM_N && mem2[len] !== MARKER) bad++;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(lat), (len == 0) ? 64'd1 : 64'(len + RDL + 2));
    check({tag, "_wr_count"}, 64'(wr_cnt), 64'(len));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(len));
    check({tag, "_rd_addr_bad"}, 64'(addr_bad), 64'd0);
    check({tag, "_bad_lines"}, 64'(bad), 64'd0);
    check({tag, "_sat_seen"}, 64'(o_sat_seen), 64'(exp_sat));
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    if (len > 0) check({tag, "_wr_lag"}, 64'(first_wr - first_rd), 64'(RDL + 1));
  endtask

  initial begin : main
    logic [15:0] v;
    int abort_at;
    i_reset_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_len = '0;
    i_op = '0; i_signed = 1'b0; i_saturate = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_rd_en", 64'(o_bram0_rd_en | o_bram1_rd_en), 64'd0);
    check("rst_wr_en", 64'(o_bram2_wr_en), 64'd0);
    check("rst_wr_data", 64'(o_bram2_wr_data == '0), 64'd1);
    check("rst_addr", 64'({o_bram0_rd_addr, o_bram2_wr_addr}), 64'd0);
    check("rst_flags", 64'({o_busy, o_done, o_sat_seen}), 64'd0);
    i_reset_n = 1'b1;
    step(); step();
    check("idle_flags", 64'({o_busy, o_done}), 64'd0);

    // ADD unsigned wrap: A=i, B=2i in every lane.
    for (int i = 0; i < 128; i++) begin
      v = 16'(i);
      mem0[i] = {LANES{v}};
      v = 16'(2 * i);
      mem1[i] = {LANES{v}};
    end
    run_job("add_wrap", 128, 0, 1'b0, 1'b0, 1'b0);
    check("add_line5_lane0", 64'(mem2[5][15:0]), 64'd15);
    check("add_line127_lane15", 64'(mem2[127][255:240]), 64'd381);

    // SUB signed: 0x8000 - 1 in lane 0 only.
    mem0[0] = '0; mem0[0][15:0] = 16'h8000;
    mem1[0] = '0; mem1[0][15:0] = 16'h0001;
    run_job("sub_sat", 1, 1, 1'b1, 1'b1, 1'b0);
    check("sub_sat_lane0", 64'(mem2[0][15:0]), 64'h8000);
    check("sub_sat_upper_zero", 64'(mem2[0][DATA_W-1:16] == '0), 64'd1);
    check("sub_sat_flag", 64'(o_sat_seen), 64'd1);
    run_job("sub_wrap", 1, 1, 1'b1, 1'b0, 1'b0);
    check("sub_wrap_lane0", 64'(mem2[0][15:0]), 64'h7FFF);
    check("sub_wrap_flag", 64'(o_sat_seen), 64'd0);

    // MAX/MIN signedness: A=0xFFFF, B=0x0001.
    mem0[0] = {LANES{16'hFFFF}};
    mem1[0] = {LANES{16'h0001}};
    run_job("max_s", 1, 2, 1'b1, 1'b1, 1'b0);
    check("max_signed", 64'(mem2[0][15:0]), 64'h0001);
    run_job("max_u", 1, 2, 1'b0, 1'b0, 1'b0);
    check("max_unsigned", 64'(mem2[0][15:0]), 64'hFFFF);
    run_job("min_s", 1, 3, 1'b1, 1'b0, 1'b0);
    check("min_signed", 64'(mem2[0][31:16]), 64'hFFFF);

    // Zero length and full-BRAM length.
    run_job("len0", 0, 0, 1'b0, 1'b0, 1'b0);
    fill_random(MEM_N);
    run_job("len_full", MEM_N, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b0);

    // Random jobs.
    for (int r = 0; r < 6; r++) begin
      fill_random(48);
      run_job("rnd", int'($urandom_range(1, 48)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'b0);
    end

    // A start pulse during RUN is ignored.
    fill_random(64);
    run_job("poke_start", 64, 0, 1'b1, 1'b1, 1'b1);

    // Abort ten cycles into a 128-line run.
    fill_random(128);
    reset_counts();
    i_start = 1'b1; i_len = 10'd128; i_op = 2'd0; i_signed = 1'b0; i_saturate = 1'b0;
    step();
    i_start = 1'b0;
    repeat (9) step();
    i_abort = 1'b1;
    abort_at = cyc;
    step();
    i_abort = 1'b0;
    check("abort_rd_en", 64'(o_bram0_rd_en), 64'd0);
    repeat (20) step();
    check("abort_no_late_wr", 64'(last_wr <= abort_at), 64'd1);
    check("abort_wr_count", 64'(wr_cnt), 64'(9 - RDL));
    check("abort_flags", 64'({o_busy, o_done}), 64'd0);
    fill_random(32);
    run_job("after_abort", 32, 1, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset between clock edges in mid-run.
    fill_random(128);
    reset_counts();
    i_start = 1'b1; i_len = 10'd128; i_op = 2'd0; i_signed = 1'b0; i_saturate = 1'b0;
    step();
    i_start = 1'b0;
    repeat (15) step();
    check("arst_pre_busy", 64'(o_busy), 64'd1);
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("arst_rd_en", 64'(o_bram0_rd_en | o_bram1_rd_en), 64'd0);
    check("arst_wr_en", 64'(o_bram2_wr_en), 64'd0);
    check("arst_wr_data", 64'(o_bram2_wr_data == '0), 64'd1);
    check("arst_addr", 64'({o_bram0_rd_addr, o_bram1_rd_addr, o_bram2_wr_addr}), 64'd0);
    check("arst_flags", 64'({o_busy, o_done, o_sat_seen}), 64'd0);
    step(); step();
    i_reset_n = 1'b1;
    step();
    fill_random(16);
    run_job("after_arst", 16, 0, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
